// File: rtl/mux_arbiter_2to1.sv
// Two-requester arbiter driving a 2:1 data mux with round-robin tie-break.
// Burst limiting per grant is enabled by defining MUX_ARB_BURST_LIMIT_EN.
module mux_arbiter_2to1 #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  output logic              gnt0,
  output logic              gnt1,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              sel
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t state_r, state_nxt_s;
  logic   last_owner_r, last_owner_nxt_s;
  logic   sel_r, sel_nxt_s;
  logic   gnt0_r, gnt1_r;
  logic   xfer_s;

  assign out_valid = (gnt0_r & req0) | (gnt1_r & req1);
  assign xfer_s    = out_valid & out_ready;
  assign out_data  = sel_r ? data1 : data0;
  assign gnt0      = gnt0_r;
  assign gnt1      = gnt1_r;
  assign sel       = sel_r;

`ifdef MUX_ARB_BURST_LIMIT_EN
  logic [7:0] burst_r, burst_nxt_s;
  logic       burst_done_s;

  // The owner's MAX_BURST-th transfer completes this cycle
  assign burst_done_s = xfer_s && (burst_r == 8'(MAX_BURST - 1));
`else
  localparam int unused_max_burst = MAX_BURST;
`endif

  // Next-state, round-robin flag and burst counter update
  always_comb begin
    state_nxt_s      = state_r;
    last_owner_nxt_s = last_owner_r;
`ifdef MUX_ARB_BURST_LIMIT_EN
    burst_nxt_s      = burst_r;
`endif
    case (state_r)
      IDLE: begin
        if (req0 && req1) begin
          state_nxt_s = last_owner_r ? OWN0 : OWN1;
        end else if (req0) begin
          state_nxt_s = OWN0;
        end else if (req1) begin
          state_nxt_s = OWN1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      OWN0: begin
        if (!req0) begin
          last_owner_nxt_s = 1'b0;
          state_nxt_s      = req1 ? OWN1 : IDLE;
`ifdef MUX_ARB_BURST_LIMIT_EN
        end else if (burst_done_s) begin
          if (req1) begin
            last_owner_nxt_s = 1'b0;
            state_nxt_s      = OWN1;
          end else begin
            burst_nxt_s = 8'd0;
          end
        end else if (xfer_s && (burst_r != 8'hFF)) begin
          burst_nxt_s = burst_r + 8'd1;
`endif
        end else begin
          state_nxt_s = OWN0;
        end
      end
      OWN1: begin
        if (!req1) begin
          last_owner_nxt_s = 1'b1;
          state_nxt_s      = req0 ? OWN0 : IDLE;
`ifdef MUX_ARB_BURST_LIMIT_EN
        end else if (burst_done_s) begin
          if (req0) begin
            last_owner_nxt_s = 1'b1;
            state_nxt_s      = OWN0;
          end else begin
            burst_nxt_s = 8'd0;
          end
        end else if (xfer_s && (burst_r != 8'hFF)) begin
          burst_nxt_s = burst_r + 8'd1;
`endif
        end else begin
          state_nxt_s = OWN1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
`ifdef MUX_ARB_BURST_LIMIT_EN
    if (state_nxt_s != state_r) begin
      burst_nxt_s = 8'd0;
    end else begin
      burst_nxt_s = burst_nxt_s;
    end
`endif
  end

  // Mux select follows the owner and holds its last value while idle
  always_comb begin
    sel_nxt_s = sel_r;
    case (state_nxt_s)
      OWN0:    sel_nxt_s = 1'b0;
      OWN1:    sel_nxt_s = 1'b1;
      default: sel_nxt_s = sel_r;
    endcase
  end

  // State and registered outputs; grants decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      last_owner_r <= 1'b1;
      sel_r        <= 1'b0;
      gnt0_r       <= 1'b0;
      gnt1_r       <= 1'b0;
`ifdef MUX_ARB_BURST_LIMIT_EN
      burst_r      <= 8'd0;
`endif
    end else begin
      state_r      <= state_nxt_s;
      last_owner_r <= last_owner_nxt_s;
      sel_r        <= sel_nxt_s;
      gnt0_r       <= (state_nxt_s == OWN0);
      gnt1_r       <= (state_nxt_s == OWN1);
`ifdef MUX_ARB_BURST_LIMIT_EN
      burst_r      <= burst_nxt_s;
`endif
    end
  end

endmodule

// File: tb/tb_mux_arbiter_2to1.sv
// Self-checking bench for mux_arbiter_2to1: directed scenarios plus a
// randomized run checked against an owner/burst-count reference model.
module tb_mux_arbiter_2to1;
  localparam int DW = 8;
  localparam int MB = 4;
`ifdef MUX_ARB_BURST_LIMIT_EN
  localparam bit LIM = 1'b1;
`else
  localparam bit LIM = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] data0 = '0, data1 = '0;
  logic          gnt0, gnt1, out_valid, sel;
  logic [DW-1:0] out_data;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: owner is -1 (nobody), 0 or 1
  int m_owner = -1;
  int m_burst = 0;
  int m_last  = 1;
  int m_sel   = 0;

  always #5 clk = ~clk;

  mux_arbiter_2to1 #(.DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .data0(data0), .data1(data1), .gnt0(gnt0), .gnt1(gnt1),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data), .sel(sel)
  );

  task automatic model_step();
    bit mine, other, xfer;
    if (rst) begin
      m_owner = -1; m_burst = 0; m_last = 1; m_sel = 0;
    end else if (m_owner < 0) begin
      if (req0 && req1) m_owner = 1 - m_last;
      else if (req0)    m_owner = 0;
      else if (req1)    m_owner = 1;
      m_burst = 0;
    end else begin
      mine  = (m_owner == 0) ? req0 : req1;
      other = (m_owner == 0) ? req1 : req0;
      xfer  = mine && out_ready;
      if (!mine) begin
        m_last  = m_owner;
        m_owner = other ? 1 - m_owner : -1;
        m_burst = 0;
      end else if (LIM && xfer) begin
        m_burst++;
        if (m_burst >= MB) begin
          m_burst = 0;
          if (other) begin
            m_last  = m_owner;
            m_owner = 1 - m_owner;
          end
        end
      end
    end
    if (m_owner >= 0) m_sel = m_owner;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; out_ready = 1'b1;
    tick(); tick();
    n_cmp++; if (gnt0 !== 1'b0) begin n_err++; $display("FAIL reset_gnt0: got %b want 0", gnt0); end
    n_cmp++; if (gnt1 !== 1'b0) begin n_err++; $display("FAIL reset_gnt1: got %b want 0", gnt1); end
    n_cmp++; if (sel !== 1'b0) begin n_err++; $display("FAIL reset_sel: got %b want 0", sel); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_single();
    rst = 1'b1; tick();
    rst = 1'b0; req0 = 1'b1; req1 = 1'b0; data0 = 8'hA5; out_ready = 1'b1;
    tick();
    n_cmp++; if (gnt0 !== 1'b1) begin n_err++; $display("FAIL single_gnt0: got %b want 1", gnt0); end
    n_cmp++; if (out_data !== 8'hA5) begin n_err++; $display("FAIL single_data: got %h want a5", out_data); end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", out_valid); end
  endtask

  task automatic test_tie();
    rst = 1'b1; tick();
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1; out_ready = 1'b1;
    data0 = 8'($urandom); data1 = 8'($urandom);
    tick();
    n_cmp++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin n_err++; $display("FAIL tie_first: got gnt0=%b gnt1=%b want 1/0", gnt0, gnt1); end
    req0 = 1'b0;
    tick();
    n_cmp++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin n_err++; $display("FAIL tie_handover: got gnt0=%b gnt1=%b want 0/1", gnt0, gnt1); end
    n_cmp++; if (sel !== 1'b1) begin n_err++; $display("FAIL tie_sel: got %b want 1", sel); end
    n_cmp++; if (out_data !== data1) begin n_err++; $display("FAIL tie_data: got %h want %h", out_data, data1); end
  endtask

  task automatic test_burst();
    bit exp_g0;
    rst = 1'b1; tick();
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1; out_ready = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      tick();
      exp_g0 = LIM ? ((((c - 1) / MB) % 2) == 0) : 1'b1;
      n_cmp++;
      if (gnt0 !== exp_g0 || gnt1 !== !exp_g0) begin
        n_err++; $display("FAIL burst_c%0d: got gnt0=%b gnt1=%b want %b/%b", c, gnt0, gnt1, exp_g0, !exp_g0);
      end
    end
  endtask

  task automatic test_stall();
    rst = 1'b1; tick();
    rst = 1'b0; req0 = 1'b1; req1 = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0; req1 = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_cmp++;
      if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
        n_err++; $display("FAIL stall_c%0d: got gnt0=%b gnt1=%b want 1/0", c, gnt0, gnt1);
      end
    end
    out_ready = 1'b1;
    tick(); tick(); tick();
    n_cmp++; if (gnt0 !== 1'b1) begin n_err++; $display("FAIL stall_resume: got gnt0=%b want 1", gnt0); end
    tick();
    n_cmp++; if (gnt1 !== LIM) begin n_err++; $display("FAIL stall_switch: got gnt1=%b want %b", gnt1, LIM); end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; tick();
    rst = 1'b0; req0 = 1'b0; req1 = 1'b1; out_ready = 1'b1;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    n_cmp++; if (gnt1 !== 1'b0 || gnt0 !== 1'b0) begin n_err++; $display("FAIL midrst_gnt: got gnt0=%b gnt1=%b want 0/0", gnt0, gnt1); end
    n_cmp++; if (sel !== 1'b0) begin n_err++; $display("FAIL midrst_sel: got %b want 0", sel); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1;
    tick();
    n_cmp++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin n_err++; $display("FAIL midrst_regrant: got gnt0=%b gnt1=%b want 1/0", gnt0, gnt1); end
  endtask

  task automatic test_random();
    logic          e_g0, e_g1, e_sel, e_valid;
    logic [DW-1:0] e_data;
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 49) == 0);
      req0      = ($urandom_range(0, 3) != 0);
      req1      = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      data0     = 8'($urandom);
      data1     = 8'($urandom);
      tick();
      e_g0    = (m_owner == 0);
      e_g1    = (m_owner == 1);
      e_sel   = (m_sel == 1);
      e_valid = (e_g0 && req0) || (e_g1 && req1);
      e_data  = e_sel ? data1 : data0;
      n_cmp++;
      if (gnt0 !== e_g0 || gnt1 !== e_g1 || sel !== e_sel || out_valid !== e_valid || out_data !== e_data) begin
        n_err++;
        $display("FAIL random_c%0d: got g0=%b g1=%b sel=%b v=%b d=%h want g0=%b g1=%b sel=%b v=%b d=%h",
                 c, gnt0, gnt1, sel, out_valid, out_data, e_g0, e_g1, e_sel, e_valid, e_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_burst();
    test_stall();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mux_arbiter_2to1.md
MUX_ARBITER_2TO1 -- requirements
Module: mux_arbiter_2to1

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of each requester data bus and out_data.
REQ-002 SHALL have parameter MAX_BURST, default 4, maximum consecutive transfers per grant (range 1..255).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports req0, req1  input  1  requester has a valid word.
REQ-006 SHALL have ports data0, data1  input  DATA_W  requester data, held stable while req high.
REQ-007 SHALL have ports gnt0, gnt1  output  1  registered grant, one-hot or zero.
REQ-008 SHALL have port out_ready  input  1  downstream accepts a word this cycle.
REQ-009 SHALL have port out_valid  output  1  granted requester's req gated by its grant.
REQ-010 SHALL have port out_data  output  DATA_W  2:1 mux output: data1 when sel=1, else data0.
REQ-011 SHALL have port sel  output  1  registered mux select; 1 means requester 1 owns the mux.

Function
REQ-012 SHALL implement FSM states IDLE, OWN0, OWN1; gnt0=1 only in OWN0, gnt1=1 only in OWN1.
REQ-013 SHALL define a transfer as out_valid & out_ready; out_valid = (gnt0 & req0) | (gnt1 & req1), combinational.
REQ-014 IDLE: if exactly one req high, SHALL move to that requester's OWN state next cycle (1-cycle grant latency).
REQ-015 IDLE, both req high: SHALL grant the requester not last served (round-robin flag last_owner); last_owner resets to 1, so requester 0 wins the first tie.
REQ-016 OWNx: SHALL remain while reqx high and burst count < MAX_BURST.
REQ-017 OWNx, reqx low: SHALL move to OWN(other) if other req high, else IDLE, next cycle; no idle bubble when the other requester is waiting.
REQ-018 OWNx, MAX_BURST-th transfer completes and other req high: SHALL move to OWN(other) next cycle; if other req low, SHALL stay OWNx and clear burst count.
REQ-019 Burst counter SHALL clear on every state change and increment only on a transfer; SHALL saturate, never wrap.
REQ-020 last_owner SHALL update to x when leaving OWNx.
REQ-021 sel SHALL equal 1 in OWN1, 0 in OWN0, and hold its previous value in IDLE.
REQ-022 out_ready low SHALL stall: no state change except on req drop per REQ-017.
REQ-023 Grants SHALL never be simultaneously high.

Reset
REQ-024 With rst high at a clock edge: state=IDLE, gnt0=gnt1=0, sel=0, burst count=0, last_owner=1.
REQ-025 rst mid-burst SHALL abort ownership immediately; out_valid=0 in the cycle after reset asserts; no transfer is counted during reset.
REQ-026 First grant after rst deasserts SHALL follow REQ-014/015 with no extra delay.

Configuration
REQ-027 Macro MUX_ARB_BURST_LIMIT_EN SHALL gate burst limiting.
REQ-028 Defined: REQ-016/018/019 apply as written.
REQ-029 Undefined: burst counter and MAX_BURST logic SHALL be absent; ownership held until owner's req drops (REQ-017 only); MAX_BURST parameter is accepted but ignored.

Verification
REQ-030 Reset: rst=1 for 2 cycles with req0=req1=1 -> gnt0=gnt1=0, sel=0, out_valid=0.
REQ-031 Single requester: req0=1, data0=8'hA5, out_ready=1 from IDLE -> gnt0=1 one cycle later, out_data=8'hA5, out_valid=1.
REQ-032 Tie after reset: req0=req1=1 in IDLE -> OWN0 first; after req0 drops, gnt1=1 next cycle, sel=1, out_data=data1.
REQ-033 Burst limit (macro defined, MAX_BURST=4): req0=req1=1, out_ready=1 -> exactly 4 transfers on gnt0, then gnt1 for 4, alternating; macro undefined -> gnt0 held indefinitely.
REQ-034 Stall: OWN0 with out_ready=0 for 10 cycles, req1=1 -> gnt0 held, burst count unchanged, no switch.
REQ-035 Reset mid-burst: rst asserted after 2 transfers in OWN1 -> IDLE, sel=0; after release with both req high -> OWN0 granted (last_owner=1).
